// File: rtl/bus_arbiter_if.sv
// Request/response bundle between two requesters (m0 fetch, m1 data) and one memory bus.
// The master modport is the arbiter side; slave is the requester/memory environment.
interface bus_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13
);
  logic                  m0_reqcyc, m1_reqcyc;
  logic [DATA_WIDTH-1:0] m0_req, m1_req;
  logic [TAG_WIDTH-1:0]  m0_reqtag, m1_reqtag;
  logic                  m0_reqack, m1_reqack;
  logic                  m0_respcyc, m1_respcyc;
  logic [DATA_WIDTH-1:0] m0_resp, m1_resp;

  logic                  bus_reqcyc;
  logic [DATA_WIDTH-1:0] bus_req;
  logic [TAG_WIDTH-1:0]  bus_reqtag;
  logic                  bus_reqack;
  logic                  bus_respcyc;
  logic [DATA_WIDTH-1:0] bus_resp;
  logic                  bus_respack;

  modport master (
    input  m0_reqcyc, m1_reqcyc, m0_req, m1_req, m0_reqtag, m1_reqtag,
    output m0_reqack, m1_reqack, m0_respcyc, m1_respcyc, m0_resp, m1_resp,
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    input  bus_reqack, bus_respcyc, bus_resp
  );

  modport slave (
    output m0_reqcyc, m1_reqcyc, m0_req, m1_req, m0_reqtag, m1_reqtag,
    input  m0_reqack, m1_reqack, m0_respcyc, m1_respcyc, m0_resp, m1_resp,
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    output bus_reqack, bus_respcyc, bus_resp
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-requester memory bus arbiter: IDLE/ADDR/WDATA/RESP transaction FSM.
// Define BUS_ARB_RR_EN for round-robin tie breaking; default is fixed m1-over-m0 priority.
module bus_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.master bif,
  output logic          owner,
  output logic          busy,
  output logic          err_stray
);
  typedef enum logic [1:0] {IDLE, ADDR, WDATA, RESP} state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  beat_seen_q, beat_seen_d;
  logic                  err_stray_q, err_stray_d;
  logic [3:0]            beat_cnt_q, beat_cnt_d;
  logic                  any_req, win;
  logic                  own_cyc;
  logic [DATA_WIDTH-1:0] own_req;
  logic [TAG_WIDTH-1:0]  own_tag;

  assign any_req = bif.m0_reqcyc | bif.m1_reqcyc;
  assign own_cyc = owner_q ? bif.m1_reqcyc : bif.m0_reqcyc;
  assign own_req = owner_q ? bif.m1_req    : bif.m0_req;
  assign own_tag = owner_q ? bif.m1_reqtag : bif.m0_reqtag;

`ifdef BUS_ARB_RR_EN
  // rr_q set means m1 wins the next simultaneous contest.
  logic rr_q, rr_d;

  assign win = (bif.m0_reqcyc && bif.m1_reqcyc) ? rr_q : bif.m1_reqcyc;

  always_comb begin
    rr_d = rr_q;
    if (state_q == IDLE && any_req) rr_d = ~win;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_q <= 1'b1;
    else       rr_q <= rr_d;
  end
`else
  assign win = bif.m1_reqcyc;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    beat_seen_d = beat_seen_q;
    beat_cnt_d  = beat_cnt_q;
    // Any beat outside RESP has no read waiting for it.
    err_stray_d = bif.bus_respcyc && (state_q != RESP);
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = win;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (!own_cyc) begin
          state_d = IDLE;
        end else if (bif.bus_reqack) begin
          if (own_tag[TAG_WIDTH-1]) begin
            state_d     = RESP;
            beat_seen_d = 1'b0;
            beat_cnt_d  = '0;
          end else begin
            state_d = WDATA;
          end
        end
      end
      WDATA: begin
        if (!own_cyc) state_d = IDLE;
      end
      RESP: begin
        if (bif.bus_respcyc) begin
          beat_seen_d = 1'b1;
          if (beat_cnt_q != 4'hF) beat_cnt_d = beat_cnt_q + 4'd1;
        end else if (beat_seen_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      beat_seen_q <= 1'b0;
      err_stray_q <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      beat_seen_q <= beat_seen_d;
      err_stray_q <= err_stray_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  // Outputs decode straight from state so reset blanks them without waiting for a clock.
  assign bif.bus_reqcyc  = ((state_q == ADDR) || (state_q == WDATA)) && own_cyc;
  assign bif.bus_req     = own_req;
  assign bif.bus_reqtag  = own_tag;
  assign bif.bus_respack = bif.bus_respcyc;

  assign bif.m0_reqack  = (state_q == ADDR) && !owner_q && bif.bus_reqack;
  assign bif.m1_reqack  = (state_q == ADDR) &&  owner_q && bif.bus_reqack;
  assign bif.m0_respcyc = (state_q == RESP) && !owner_q && bif.bus_respcyc;
  assign bif.m1_respcyc = (state_q == RESP) &&  owner_q && bif.bus_respcyc;
  assign bif.m0_resp    = bif.bus_resp;
  assign bif.m1_resp    = bif.bus_resp;

  assign owner     = owner_q;
  assign busy      = (state_q != IDLE);
  assign err_stray = err_stray_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized transactions
// checked against a grant-rule model (fixed priority or round-robin by BUS_ARB_RR_EN).
module tb_bus_arbiter;
  localparam int DW = 64;
  localparam int TW = 13;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic owner, busy, err_stray;
  int   checks = 0;
  int   errors = 0;
  int   last_grant = 0;  // model: requester granted most recently (0 after reset, so m1 wins a tie)

  always #5 clk = ~clk;

  bus_arbiter_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bif ();

  bus_arbiter #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset), .bif(bif),
    .owner(owner), .busy(busy), .err_stray(err_stray)
  );

  // Grant rule: single requester wins; on a tie, m1 (fixed) or the one not granted last (RR).
  function automatic int pick(input bit r0, input bit r1);
    if (r0 && r1) begin
`ifdef BUS_ARB_RR_EN
      return 1 - last_grant;
`else
      return 1;
`endif
    end
    return r1 ? 1 : 0;
  endfunction

  function automatic logic ack_of(input int n);
    return (n != 0) ? bif.m1_reqack : bif.m0_reqack;
  endfunction
  function automatic logic rcyc_of(input int n);
    return (n != 0) ? bif.m1_respcyc : bif.m0_respcyc;
  endfunction
  function automatic logic [DW-1:0] resp_of(input int n);
    return (n != 0) ? bif.m1_resp : bif.m0_resp;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bif.m0_reqcyc = 1'b0; bif.m1_reqcyc = 1'b0;
    bif.m0_req = '0;      bif.m1_req = '0;
    bif.m0_reqtag = '0;   bif.m1_reqtag = '0;
    bif.bus_reqack = 1'b0; bif.bus_respcyc = 1'b0; bif.bus_resp = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    last_grant = 0;
    tick();
  endtask

  task automatic drive_m(input int n, input bit cyc, input logic [TW-1:0] tag, input logic [DW-1:0] data);
    if (n != 0) begin bif.m1_reqcyc = cyc; bif.m1_reqtag = tag; bif.m1_req = data; end
    else        begin bif.m0_reqcyc = cyc; bif.m0_reqtag = tag; bif.m0_req = data; end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    checks++;
    if ({owner, busy, err_stray, bif.bus_reqcyc, bif.m0_reqack, bif.m1_reqack, bif.m0_respcyc, bif.m1_respcyc} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=00000000",
               {owner, busy, err_stray, bif.bus_reqcyc, bif.m0_reqack, bif.m1_reqack, bif.m0_respcyc, bif.m1_respcyc});
    end
    reset = 1'b0;
    last_grant = 0;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy got=%b exp=0", busy); end
  endtask

  task automatic test_fetch();
    logic [DW-1:0] d;
    int w;
    drive_m(0, 1'b1, {1'b1, 12'h0A5}, 64'h1000);
    #1;
    checks++;
    if (bif.bus_reqcyc !== 1'b0) begin errors++; $display("FAIL fetch_idle_reqcyc got=%b exp=0", bif.bus_reqcyc); end
    w = pick(1'b1, 1'b0); last_grant = w;
    tick();
    checks++;
    if ({bif.bus_reqcyc, owner, busy} !== {1'b1, w[0], 1'b1}) begin
      errors++; $display("FAIL fetch_grant got=%b exp=%b", {bif.bus_reqcyc, owner, busy}, {1'b1, w[0], 1'b1});
    end
    checks++;
    if (bif.bus_req !== 64'h1000 || bif.bus_reqtag !== {1'b1, 12'h0A5}) begin
      errors++; $display("FAIL fetch_addr got=%h/%h exp=1000/%h", bif.bus_req, bif.bus_reqtag, {1'b1, 12'h0A5});
    end
    bif.bus_reqack = 1'b1;
    #1;
    checks++;
    if ({bif.m0_reqack, bif.m1_reqack} !== 2'b10) begin
      errors++; $display("FAIL fetch_ack got=%b exp=10", {bif.m0_reqack, bif.m1_reqack});
    end
    tick();
    bif.bus_reqack = 1'b0;
    bif.m0_reqcyc = 1'b0;
    #1;
    checks++;
    if ({bif.bus_reqcyc, busy} !== 2'b01) begin errors++; $display("FAIL fetch_resp_state got=%b exp=01", {bif.bus_reqcyc, busy}); end
    tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL fetch_wait_first_beat busy got=%b exp=1", busy); end
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom};
      bif.bus_respcyc = 1'b1; bif.bus_resp = d;
      #1;
      checks++;
      if ({bif.m0_respcyc, bif.m1_respcyc, bif.bus_respack} !== 3'b101 || bif.m0_resp !== d) begin
        errors++; $display("FAIL fetch_beat%0d got=%b/%h exp=101/%h", i, {bif.m0_respcyc, bif.m1_respcyc, bif.bus_respack}, bif.m0_resp, d);
      end
      tick();
      checks++;
      if (err_stray !== 1'b0) begin errors++; $display("FAIL fetch_no_stray%0d got=%b exp=0", i, err_stray); end
    end
    bif.bus_respcyc = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL fetch_done busy got=%b exp=0", busy); end
  endtask

  task automatic test_write();
    logic [DW-1:0] d;
    int w;
    drive_m(1, 1'b1, {1'b0, 12'h123}, 64'h2000);
    w = pick(1'b0, 1'b1); last_grant = w;
    tick();
    checks++;
    if (owner !== w[0] || bif.bus_reqcyc !== 1'b1 || bif.bus_req !== 64'h2000) begin
      errors++; $display("FAIL write_addr got=%b/%b/%h exp=%b/1/2000", owner, bif.bus_reqcyc, bif.bus_req, w[0]);
    end
    bif.bus_reqack = 1'b1;
    #1;
    checks++;
    if ({bif.m1_reqack, bif.m0_reqack} !== 2'b10) begin errors++; $display("FAIL write_ack got=%b exp=10", {bif.m1_reqack, bif.m0_reqack}); end
    tick();
    bif.bus_reqack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom};
      bif.m1_req = d;
      bif.bus_respcyc = (i == 3);
      #1;
      checks++;
      if (bif.bus_reqcyc !== 1'b1 || bif.bus_req !== d || bif.m1_respcyc !== 1'b0 || bif.m0_respcyc !== 1'b0) begin
        errors++; $display("FAIL write_beat%0d got=%b/%h/%b exp=1/%h/0", i, bif.bus_reqcyc, bif.bus_req, bif.m1_respcyc, d);
      end
      tick();
      checks++;
      if (err_stray !== (i == 3)) begin errors++; $display("FAIL write_stray%0d got=%b exp=%b", i, err_stray, (i == 3)); end
    end
    bif.m1_reqcyc = 1'b0;
    bif.bus_respcyc = 1'b0;
    #1;
    checks++;
    if ({bif.bus_reqcyc, busy} !== 2'b01) begin errors++; $display("FAIL write_drop got=%b exp=01", {bif.bus_reqcyc, busy}); end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL write_idle busy got=%b exp=0", busy); end
  endtask

  task automatic test_stray();
    bif.bus_respcyc = 1'b1;
    bif.bus_resp = {$urandom, $urandom};
    #1;
    checks++;
    if ({bif.bus_respack, bif.m0_respcyc, bif.m1_respcyc} !== 3'b100) begin
      errors++; $display("FAIL stray_ack got=%b exp=100", {bif.bus_respack, bif.m0_respcyc, bif.m1_respcyc});
    end
    tick();
    bif.bus_respcyc = 1'b0;
    checks++;
    if ({err_stray, busy} !== 2'b10) begin errors++; $display("FAIL stray_pulse got=%b exp=10", {err_stray, busy}); end
    tick();
    checks++;
    if (err_stray !== 1'b0) begin errors++; $display("FAIL stray_one_cycle got=%b exp=0", err_stray); end
  endtask

  task automatic test_contention();
    int w;
    apply_reset();
    drive_m(0, 1'b1, {1'b1, 12'h001}, 64'hA000);
    drive_m(1, 1'b1, {1'b1, 12'h002}, 64'hB000);
    for (int k = 0; k < 3; k++) begin
      w = pick(1'b1, 1'b1); last_grant = w;
      tick();
      checks++;
      if (owner !== w[0] || bif.bus_req !== ((w != 0) ? 64'hB000 : 64'hA000)) begin
        errors++; $display("FAIL contest%0d_grant got=%b/%h exp=%b", k, owner, bif.bus_req, w[0]);
      end
      bif.bus_reqack = 1'b1;
      #1;
      checks++;
      if ({bif.m1_reqack, bif.m0_reqack} !== ((w != 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL contest%0d_ack got=%b owner_exp=%0d", k, {bif.m1_reqack, bif.m0_reqack}, w);
      end
      tick();
      bif.bus_reqack = 1'b0;
      bif.bus_respcyc = 1'b1;
      bif.bus_resp = {$urandom, $urandom};
      #1;
      checks++;
      if ({bif.m1_respcyc, bif.m0_respcyc} !== ((w != 0) ? 2'b10 : 2'b01) || owner !== w[0]) begin
        errors++; $display("FAIL contest%0d_route got=%b/%b owner_exp=%0d", k, {bif.m1_respcyc, bif.m0_respcyc}, owner, w);
      end
      tick();
      bif.bus_respcyc = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL contest%0d_done busy got=%b exp=0", k, busy); end
    end
    bif.m1_reqcyc = 1'b0;
    w = pick(1'b1, 1'b0); last_grant = w;
    tick();
    checks++;
    if (owner !== 1'b0 || bif.bus_reqcyc !== 1'b1 || bif.bus_req !== 64'hA000) begin
      errors++; $display("FAIL contest_m0_after got=%b/%b/%h exp=0/1/a000", owner, bif.bus_reqcyc, bif.bus_req);
    end
    bif.m0_reqcyc = 1'b0;
    #1;
    checks++;
    if (bif.bus_reqcyc !== 1'b0) begin errors++; $display("FAIL abort_reqcyc got=%b exp=0", bif.bus_reqcyc); end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    int w;
    drive_m(1, 1'b1, {1'b1, 12'h0FF}, 64'h3000);
    w = pick(1'b0, 1'b1); last_grant = w;
    tick();
    bif.bus_reqack = 1'b1;
    tick();
    bif.bus_reqack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bif.bus_respcyc = 1'b1; bif.bus_resp = {$urandom, $urandom};
      tick();
    end
    bif.bus_respcyc = 1'b1;
    #1;
    checks++;
    if (bif.m1_respcyc !== 1'b1 || owner !== 1'b1) begin
      errors++; $display("FAIL rstmid_beat3 got=%b/%b exp=1/1", bif.m1_respcyc, owner);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({owner, busy, err_stray, bif.bus_reqcyc, bif.m0_reqack, bif.m1_reqack, bif.m0_respcyc, bif.m1_respcyc} !== 8'b0) begin
      errors++; $display("FAIL rstmid_async got=%b exp=00000000",
                         {owner, busy, err_stray, bif.bus_reqcyc, bif.m0_reqack, bif.m1_reqack, bif.m0_respcyc, bif.m1_respcyc});
    end
    clear_inputs();
    tick();
    reset = 1'b0;
    last_grant = 0;
    drive_m(0, 1'b1, {1'b1, 12'h010}, 64'h4000);
    w = pick(1'b1, 1'b0); last_grant = w;
    tick();
    checks++;
    if (owner !== 1'b0 || bif.bus_reqcyc !== 1'b1 || bif.bus_req !== 64'h4000) begin
      errors++; $display("FAIL rstmid_regrant got=%b/%b/%h exp=0/1/4000", owner, bif.bus_reqcyc, bif.bus_req);
    end
    bif.bus_reqack = 1'b1;
    tick();
    bif.bus_reqack = 1'b0;
    bif.m0_reqcyc = 1'b0;
    d = {$urandom, $urandom};
    bif.bus_respcyc = 1'b1; bif.bus_resp = d;
    #1;
    checks++;
    if (bif.m0_respcyc !== 1'b1 || bif.m0_resp !== d) begin
      errors++; $display("FAIL rstmid_resp got=%b/%h exp=1/%h", bif.m0_respcyc, bif.m0_resp, d);
    end
    tick();
    bif.bus_respcyc = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_done busy got=%b exp=0", busy); end
  endtask

  task automatic test_random();
    bit r0, r1, rd;
    int w, nb;
    logic [DW-1:0] a0, a1, d;
    logic [TW-1:0] t0, t1;
    for (int it = 0; it < 40; it++) begin
      do begin
        r0 = 1'($urandom_range(0, 1));
        r1 = 1'($urandom_range(0, 1));
      end while (!(r0 || r1));
      a0 = {$urandom, $urandom}; a1 = {$urandom, $urandom};
      t0 = TW'($urandom);        t1 = TW'($urandom);
      drive_m(0, r0, t0, a0);
      drive_m(1, r1, t1, a1);
      w = pick(r0, r1); last_grant = w;
      rd = (w != 0) ? t1[TW-1] : t0[TW-1];
      tick();
      checks++;
      if (owner !== w[0] || bif.bus_reqcyc !== 1'b1 || bif.bus_req !== ((w != 0) ? a1 : a0) || bif.bus_reqtag !== ((w != 0) ? t1 : t0)) begin
        errors++; $display("FAIL rand%0d_grant got=%b/%b/%h exp=%b/1/%h", it, owner, bif.bus_reqcyc, bif.bus_req, w[0], (w != 0) ? a1 : a0);
      end
      repeat ($urandom_range(0, 2)) tick();
      if ($urandom_range(0, 7) == 0) begin
        if (w != 0) bif.m1_reqcyc = 1'b0; else bif.m0_reqcyc = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rand%0d_abort busy got=%b exp=0", it, busy); end
      end else begin
        bif.bus_reqack = 1'b1;
        #1;
        checks++;
        if (ack_of(w) !== 1'b1 || ack_of(1 - w) !== 1'b0) begin
          errors++; $display("FAIL rand%0d_ack got=%b/%b exp=1/0", it, ack_of(w), ack_of(1 - w));
        end
        tick();
        bif.bus_reqack = 1'b0;
        if (rd) begin
          nb = $urandom_range(1, 5);
          for (int b = 0; b < nb; b++) begin
            d = {$urandom, $urandom};
            bif.bus_respcyc = 1'b1; bif.bus_resp = d;
            #1;
            checks++;
            if (rcyc_of(w) !== 1'b1 || rcyc_of(1 - w) !== 1'b0 || resp_of(w) !== d) begin
              errors++; $display("FAIL rand%0d_beat%0d got=%b/%b/%h exp=1/0/%h", it, b, rcyc_of(w), rcyc_of(1 - w), resp_of(w), d);
            end
            tick();
          end
          bif.bus_respcyc = 1'b0;
        end else begin
          nb = $urandom_range(0, 4);
          for (int b = 0; b < nb; b++) begin
            d = {$urandom, $urandom};
            if (w != 0) bif.m1_req = d; else bif.m0_req = d;
            #1;
            checks++;
            if (bif.bus_reqcyc !== 1'b1 || bif.bus_req !== d) begin
              errors++; $display("FAIL rand%0d_wdata%0d got=%b/%h exp=1/%h", it, b, bif.bus_reqcyc, bif.bus_req, d);
            end
            tick();
          end
          if (w != 0) bif.m1_reqcyc = 1'b0; else bif.m0_reqcyc = 1'b0;
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rand%0d_end busy got=%b exp=0", it, busy); end
      end
      clear_inputs();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    test_reset();
    test_fetch();
    test_write();
    test_stray();
    test_contention();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
